mac_row_feeder: RTL and testbench
=================================

# mac_row_feeder

Upstream sequencer for `mac_row`. It buffers a stream of 4-bit operands (two 2-bit lanes) in a small FIFO and drives `in_w0`/`in_w1`/`inst_w` of one `mac_row`. Per job it runs a fixed program: load 2×col weights, stream N activations, then drain with idle instructions so the last partial sums reach `out_s`. It inserts bubbles automatically when the FIFO runs dry.

## Interface
- `bw`, 2: lane width; the operand is 2·bw bits.
- `col`, 4: mac_row columns; a job loads 2·col weights.
- `inst_bw`, 3: instruction width; `inst_w` = {mode, exec, load}.
- `depth`, 8: FIFO entries, power of two.
- `cnt_bw`, 8: width of the activation count.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  2·bw  operand; `[bw-1:0]` is the low lane, `[2bw-1:bw]` is the high lane.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `start`  in  1  one-cycle job request.
- `mode`  in  1  latched at start, copied to `inst_w[2]`.
- `n_act`  in  cnt_bw  activations in the job, latched at start.
- `in_w0`  out  bw  to mac_row, registered.
- `in_w1`  out  bw  to mac_row, registered.
- `inst_w`  out  inst_bw  to mac_row, registered.
- `busy`  out  1  high from the cycle after an accepted start until the job completes.
- `done`  out  1  one-cycle pulse at the end of a job.

## Operation
- Reset sets all of the following:
  - FIFO emptied; state IDLE.
  - `in_w0` = `in_w1` = 0; `inst_w` = 0.
  - `busy` = 0; `done` = 0; `in_ready` = 1.
  - A reset in the middle of a job aborts it with no `done` pulse.
- FIFO push happens when `in_valid && in_ready`.
  - Pushing while full is impossible, even if a pop occurs in the same cycle.
  - A simultaneous push and pop is allowed when the FIFO is neither full nor empty; occupancy is unchanged.
  - A push into an empty FIFO is not poppable in the same cycle.
  - Pointers wrap modulo `depth`.
- FIFO contents are accepted in every state, including IDLE.
- States:
  - IDLE → LOAD on `start`. Latch `mode` and `n_act`, clear the counters. `start` is ignored in every other state.
  - LOAD: each cycle with the FIFO non-empty, pop the head and drive `{in_w1,in_w0}` = head with `inst_w` = {mode,0,1}. Increment `wcnt`.
    - When the FIFO is empty, drive a bubble: `inst_w` = {mode,0,0}, `in_w0`/`in_w1` = 0.
    - After 2·col pops: go to EXEC, or to DRAIN if `n_act` = 0.
  - EXEC: same pop/bubble rule with `inst_w` = {mode,1,0} on pops. Increment `acnt`.
    - After `n_act` pops, go to DRAIN.
  - DRAIN: drive `inst_w` = {mode,0,0} and zero data for 2·col cycles.
    - Then assert `done` for one cycle, drop `busy`, and return to IDLE.
- The FIFO is not flushed at job end. Leftover entries serve the next job.

## Timing
- Outputs register on the same edge that pops the FIFO. An operand pushed at edge k can appear on `in_w*` at edge k+1 at the earliest, provided the feeder is in LOAD/EXEC and it is the FIFO head.
- With the FIFO pre-filled at start (edge s), the job runs as follows:
  - First weight appears after edge s+1.
  - Weights occupy 2·col cycles.
  - Activations occupy `n_act` cycles.
  - DRAIN occupies 2·col cycles.
  - `done` is high for the cycle after the final drain cycle.
  - Total `busy` cycles are 4·col + `n_act` + 1.
- Bubbles extend the LOAD/EXEC phases by one cycle each. The counters count pops only.
- `in_ready` is combinational from the full flag.

## Test plan
- **Reset:** hold `reset` 2 cycles mid-EXEC → next cycle `inst_w`=0, `in_w0`=`in_w1`=0, `busy`=0, `in_ready`=1, no `done`.
- **Weight load:** prefill 1,2,3,4,8,0,9,7; start with `mode`=0, `n_act`=0.
  - Required: 8 cycles of `inst_w`=3'b001 with (`in_w1`,`in_w0`) = (0,1),(0,2),(0,3),(1,0),(2,0),(0,0),(2,1),(1,3).
  - Then 8 cycles of 3'b000, then `done` pulses once.
- **Full job:** 8 weights followed by activations 0..15, `n_act`=16.
  - Required: 16 consecutive cycles of `inst_w`=3'b010 carrying `{in_w1,in_w0}` = 0..15 in order.
  - `busy` is high for exactly 33 cycles.
- **Starvation:** push weights one every 3 cycles → two 3'b000 bubbles between each 3'b001. `wcnt` still reaches 8 before EXEC.
- **FIFO full and wrap:** with `depth`=8, push 8 operands while idle → `in_ready`=0 and the 9th operand is not accepted.
  - Run a job while streaming 20 more operands → order is preserved across the pointer wrap.
- **Start while busy:** pulse `start` during EXEC with a different `n_act` → ignored. The job finishes with the original count and produces exactly one `done`.

Source files
------------

// File: rtl/mac_row_feeder_if.sv
// Handshake and mac_row drive bundle between an operand producer/job controller and mac_row_feeder.
interface mac_row_feeder_if #(
  parameter int bw      = 2,
  parameter int inst_bw = 3,
  parameter int cnt_bw  = 8
);
  logic [2*bw-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              start;
  logic              mode;
  logic [cnt_bw-1:0] n_act;
  logic [bw-1:0]     in_w0;
  logic [bw-1:0]     in_w1;
  logic [inst_bw-1:0] inst_w;
  logic              busy;
  logic              done;

  modport master (
    output in_data, in_valid, start, mode, n_act,
    input  in_ready, in_w0, in_w1, inst_w, busy, done
  );

  modport slave (
    input  in_data, in_valid, start, mode, n_act,
    output in_ready, in_w0, in_w1, inst_w, busy, done
  );
endinterface

// File: rtl/mac_row_feeder.sv
// Operand FIFO plus job sequencer for one mac_row: load 2*col weights, stream n_act
// activations, then drain with idle instructions; bubbles are inserted when the FIFO runs dry.
module mac_row_feeder #(
  parameter int bw      = 2,
  parameter int col     = 4,
  parameter int inst_bw = 3,
  parameter int depth   = 8,
  parameter int cnt_bw  = 8
) (
  input logic            clk,
  input logic            reset,
  mac_row_feeder_if.slave bus
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam int NW = 2 * col;
  localparam int WW = $clog2(NW + 1);
  localparam logic [PW-1:0]     P_ONE  = PW'(1);
  localparam logic [WW-1:0]     W_ONE  = WW'(1);
  localparam logic [WW-1:0]     W_LAST = WW'(NW - 1);
  localparam logic [WW-1:0]     W_NW   = WW'(NW);
  localparam logic [cnt_bw-1:0] A_ONE  = cnt_bw'(1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

  state_t state, state_n;

  logic [2*bw-1:0]    mem [depth];
  logic [2*bw-1:0]    head;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               full, empty, push, pop;

  logic [WW-1:0]      wcnt, wcnt_n, dcnt, dcnt_n;
  logic [cnt_bw-1:0]  acnt, acnt_n, nact_q, nact_n;
  logic               mode_q, mode_n, done_q, done_n;
  logic [bw-1:0]      w0_q, w1_q, w0_n, w1_n;
  logic [inst_bw-1:0] inst_q, inst_n;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign bus.in_ready = !full;
  assign bus.in_w0    = w0_q;
  assign bus.in_w1    = w1_q;
  assign bus.inst_w   = inst_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    wcnt_n  = wcnt;
    acnt_n  = acnt;
    dcnt_n  = dcnt;
    mode_n  = mode_q;
    nact_n  = nact_q;
    done_n  = 1'b0;
    w0_n    = '0;
    w1_n    = '0;
    inst_n  = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = LOAD;
          mode_n  = bus.mode;
          nact_n  = bus.n_act;
          wcnt_n  = '0;
          acnt_n  = '0;
          dcnt_n  = '0;
        end
      end
      LOAD: begin
        inst_n = {mode_q, 2'b00};
        if (!empty) begin
          pop          = 1'b1;
          {w1_n, w0_n} = head;
          inst_n       = {mode_q, 2'b01};
          wcnt_n       = wcnt + W_ONE;
          if (wcnt == W_LAST) state_n = (nact_q == '0) ? DRAIN : EXEC;
        end
      end
      EXEC: begin
        inst_n = {mode_q, 2'b00};
        if (!empty) begin
          pop          = 1'b1;
          {w1_n, w0_n} = head;
          inst_n       = {mode_q, 2'b10};
          acnt_n       = acnt + A_ONE;
          if (acnt == nact_q - A_ONE) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // 2*col idle instructions flush the row, then one extra cycle reports done.
        if (dcnt == W_NW) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          inst_n = {mode_q, 2'b00};
          dcnt_n = dcnt + W_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output stage: drive registers update on the same edge that pops the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      wcnt   <= '0;
      acnt   <= '0;
      dcnt   <= '0;
      mode_q <= 1'b0;
      nact_q <= '0;
      done_q <= 1'b0;
      w0_q   <= '0;
      w1_q   <= '0;
      inst_q <= '0;
    end else begin
      state  <= state_n;
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      wcnt   <= wcnt_n;
      acnt   <= acnt_n;
      dcnt   <= dcnt_n;
      mode_q <= mode_n;
      nact_q <= nact_n;
      done_q <= done_n;
      w0_q   <= w0_n;
      w1_q   <= w1_n;
      inst_q <= inst_n;
    end
  end

endmodule

// File: tb/tb_mac_row_feeder.sv
// Scenario bench for mac_row_feeder: accepted operands feed a scoreboard that is matched
// against every load/exec instruction the feeder issues.
module tb_mac_row_feeder;
  localparam int BW = 2;
  localparam int COL = 4;
  localparam int NW = 2 * COL;
  localparam int DEPTH = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_row_feeder_if #(.bw(BW), .inst_bw(3), .cnt_bw(CW)) bus();

  mac_row_feeder #(.bw(BW), .col(COL), .inst_bw(3), .depth(DEPTH), .cnt_bw(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];
  int mon_pops = 0;
  int job_base = 0;
  logic job_mode = 1'b0;

  // Drive one cycle of inputs; an operand is accepted when the modelled FIFO has room.
  task automatic tick(input logic v, input logic [3:0] d, input logic st, input logic md,
                      input logic [CW-1:0] na, output logic acc);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = st;
    bus.mode     = md;
    bus.n_act    = na;
    acc = v && !reset && (sb.size() < DEPTH);
    if (acc) sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic monitor();
    logic [3:0] e;
    logic [2:0] ei;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus.inst_w[1:0] != 2'b00) begin
        ei = {job_mode, ((mon_pops - job_base) < NW) ? 2'b01 : 2'b10};
        checks++;
        if (bus.inst_w !== ei) begin
          errors++;
          $display("FAIL sb_inst: got %b want %b (pop %0d)", bus.inst_w, ei, mon_pops - job_base);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_data: got %h want <no queued operand>", {bus.in_w1, bus.in_w0});
        end else begin
          e = sb.pop_front();
          if ({bus.in_w1, bus.in_w0} !== e) begin
            errors++;
            $display("FAIL sb_data: got %h want %h", {bus.in_w1, bus.in_w0}, e);
          end
        end
        mon_pops++;
      end
    end
  endtask

  task automatic test_reset();
    logic a;
    reset = 1'b1;
    tick(0, 0, 0, 0, 0, a);
    tick(0, 0, 0, 0, 0, a);
    reset = 1'b0;
    checks++;
    if ({bus.inst_w, bus.in_w1, bus.in_w0} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {bus.inst_w, bus.in_w1, bus.in_w0});
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_weight_load();
    logic a;
    logic [3:0] vals[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd0, 4'd9, 4'd7};
    logic [1:0] ew1[8]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1};
    logic [1:0] ew0[8]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 8; i++) tick(1, vals[i], 0, 0, 0, a);
    job_mode = 1'b0;
    job_base = mon_pops;
    tick(0, 0, 1, 0, 8'd0, a);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL wl_busy_start: got %b want 1", bus.busy); end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0, 0, a);
      checks++;
      if ({bus.inst_w, bus.in_w1, bus.in_w0} !== {3'b001, ew1[i], ew0[i]}) begin
        errors++;
        $display("FAIL wl_weight%0d: got %b want %b", i, {bus.inst_w, bus.in_w1, bus.in_w0},
                 {3'b001, ew1[i], ew0[i]});
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0, 0, a);
      checks++;
      if ({bus.inst_w, bus.in_w1, bus.in_w0, bus.busy, bus.done} !== 9'b000_0000_1_0) begin
        errors++;
        $display("FAIL wl_drain%0d: got %b want 000000010", i,
                 {bus.inst_w, bus.in_w1, bus.in_w0, bus.busy, bus.done});
      end
    end
    tick(0, 0, 0, 0, 0, a);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL wl_done: got done,busy=%b want 10", {bus.done, bus.busy});
    end
    tick(0, 0, 0, 0, 0, a);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL wl_done_once: got %b want 0", bus.done); end
  endtask

  task automatic test_full_job();
    logic a;
    int ai = 0, ecnt = 0, efirst = -1, elast = -1, busy_cnt = 0;
    bit fin = 0;
    for (int i = 0; i < 8; i++) tick(1, 4'(i * 3 + 1), 0, 0, 0, a);
    job_mode = 1'b0;
    job_base = mon_pops;
    tick(0, 0, 1, 0, 8'd16, a);
    if (bus.busy) busy_cnt++;
    for (int c = 1; c <= 80 && !fin; c++) begin
      tick(ai < 16, 4'(ai), 0, 0, 0, a);
      if (a) ai++;
      if (bus.busy) busy_cnt++;
      if (bus.inst_w == 3'b010) begin
        checks++;
        if ({bus.in_w1, bus.in_w0} !== 4'(ecnt)) begin
          errors++; $display("FAIL fj_act%0d: got %h want %h", ecnt, {bus.in_w1, bus.in_w0}, 4'(ecnt));
        end
        if (efirst < 0) efirst = c;
        elast = c;
        ecnt++;
      end
      if (bus.done) fin = 1;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL fj_timeout: got no done want done within 80 cycles"); end
    checks++;
    if (busy_cnt != 33) begin errors++; $display("FAIL fj_busy_cycles: got %0d want 33", busy_cnt); end
    checks++;
    if (ecnt != 16) begin errors++; $display("FAIL fj_exec_count: got %0d want 16", ecnt); end
    checks++;
    if (elast - efirst != 15) begin
      errors++; $display("FAIL fj_exec_contiguous: got span %0d want 15", elast - efirst);
    end
    tick(0, 0, 0, 0, 0, a);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL fj_after: got done,busy=%b want 00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_starvation();
    logic a, v;
    logic [2:0] ex;
    bit is_pop;
    int pushed = 0;
    job_mode = 1'b1;
    job_base = mon_pops;
    tick(1, 4'hA, 1, 1, 8'd2, a);
    if (a) pushed++;
    for (int i = 1; i <= 37; i++) begin
      v = (i % 3 == 0) && (pushed < 10);
      tick(v, 4'(pushed * 5 + 3), 0, 0, 0, a);
      if (a) pushed++;
      is_pop = (i <= 28) && (i % 3 == 1);
      if (i <= 36) begin
        ex = is_pop ? ((i <= 22) ? 3'b101 : 3'b110) : 3'b100;
        checks++;
        if (bus.inst_w !== ex) begin
          errors++; $display("FAIL st_inst%0d: got %b want %b", i, bus.inst_w, ex);
        end
        if (!is_pop) begin
          checks++;
          if ({bus.in_w1, bus.in_w0} !== 4'h0) begin
            errors++; $display("FAIL st_bubble_data%0d: got %h want 0", i, {bus.in_w1, bus.in_w0});
          end
        end
      end
      checks++;
      if ({bus.busy, bus.done} !== {i <= 36, i == 37}) begin
        errors++;
        $display("FAIL st_status%0d: got busy,done=%b want %b", i, {bus.busy, bus.done},
                 {i <= 36, i == 37});
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic a, st;
    int si = 0, ecnt = 0, dones = 0, busy_cnt = 0, extra = 0;
    bit fired = 0;
    for (int i = 0; i < 8; i++) tick(1, 4'(i + 5), 0, 0, 0, a);
    job_mode = 1'b0;
    job_base = mon_pops;
    tick(0, 0, 1, 0, 8'd4, a);
    if (bus.busy) busy_cnt++;
    for (int c = 1; c <= 80 && dones == 0; c++) begin
      st = (ecnt > 0) && !fired;
      tick(si < 6, 4'(9 + si * 7), st, 1'b1, 8'd9, a);
      if (st) fired = 1;
      if (a) si++;
      if (bus.busy) busy_cnt++;
      if (bus.inst_w == 3'b010) ecnt++;
      if (bus.done) dones++;
    end
    for (int c = 0; c < 12; c++) begin
      tick(0, 0, 0, 0, 0, a);
      if (bus.busy || bus.done) extra++;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL sb_busy_done: got %0d dones want 1", dones); end
    checks++;
    if (ecnt != 4) begin errors++; $display("FAIL sb_busy_exec_count: got %0d want 4", ecnt); end
    checks++;
    if (busy_cnt != 21) begin errors++; $display("FAIL sb_busy_cycles: got %0d want 21", busy_cnt); end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL sb_busy_restart: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_fifo_full_wrap();
    logic a;
    int k = 0, si = 0, ecnt = 0, busy_cnt = 0;
    bit fin = 0;
    while (sb.size() < DEPTH && k < 20) begin
      tick(1, 4'(k + 2), 0, 0, 0, a);
      k++;
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ff_ready_full: got %b want 0", bus.in_ready); end
    tick(1, 4'hF, 0, 0, 0, a);
    checks++;
    if ({bus.in_ready, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL ff_ninth: got ready,busy=%b want 00", {bus.in_ready, bus.busy});
    end
    job_mode = 1'b0;
    job_base = mon_pops;
    tick(0, 0, 1, 0, 8'd20, a);
    if (bus.busy) busy_cnt++;
    for (int c = 1; c <= 120 && !fin; c++) begin
      tick(si < 20, 4'(si * 3 + 1), 0, 0, 0, a);
      if (a) si++;
      if (bus.busy) busy_cnt++;
      if (bus.inst_w == 3'b010) ecnt++;
      if (bus.done) fin = 1;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL ff_timeout: got no done want done within 120 cycles"); end
    checks++;
    if (ecnt != 20) begin errors++; $display("FAIL ff_exec_count: got %0d want 20", ecnt); end
    checks++;
    if (busy_cnt != 37) begin errors++; $display("FAIL ff_busy_cycles: got %0d want 37", busy_cnt); end
  endtask

  task automatic test_reset_mid_exec();
    logic a;
    int si = 0, bad = 0;
    bit in_exec = 0;
    for (int i = 0; i < 8; i++) tick(1, 4'(15 - i), 0, 0, 0, a);
    job_mode = 1'b0;
    job_base = mon_pops;
    tick(0, 0, 1, 0, 8'd10, a);
    for (int c = 0; c < 40 && !in_exec; c++) begin
      tick(si < 10, 4'(si), 0, 0, 0, a);
      if (a) si++;
      if (bus.inst_w == 3'b010) in_exec = 1;
    end
    checks++;
    if (!in_exec) begin errors++; $display("FAIL rx_timeout: got no exec want exec within 40 cycles"); end
    reset = 1'b1;
    sb.delete();
    tick(0, 0, 0, 0, 0, a);
    tick(0, 0, 0, 0, 0, a);
    reset = 1'b0;
    checks++;
    if ({bus.inst_w, bus.in_w1, bus.in_w0} !== 7'b0) begin
      errors++; $display("FAIL rx_outputs: got %b want 0", {bus.inst_w, bus.in_w1, bus.in_w0});
    end
    checks++;
    if ({bus.busy, bus.done, bus.in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rx_status: got busy,done,ready=%b want 001", {bus.busy, bus.done, bus.in_ready});
    end
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, 0, 0, 0, a);
      if (bus.busy || bus.done) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rx_no_done: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.n_act    = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_weight_load();
    test_full_job();
    test_starvation();
    test_start_while_busy();
    test_fifo_full_wrap();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
